// File: rtl/data_mem_ctrl_pkg.sv
// data_mem_ctrl_pkg: shared widths, opcode encodings and FSM states for the data-side memory controller
package data_mem_ctrl_pkg;
  localparam int DAT_W = 32;
  localparam int OP_W = 4;
  localparam logic [1:0] IO_WIN = 2'b11;
  typedef enum logic [OP_W-1:0] {OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_SB, OP_SH, OP_SW} op_e;
  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR} state_e;
endpackage

// File: rtl/data_mem_ctrl_load_extend.sv
// data_mem_ctrl_load_extend: sign/zero extension of an assembled little-endian load word
module data_mem_ctrl_load_extend
  import data_mem_ctrl_pkg::*;
(
  input  op_e              op_i,
  input  logic [DAT_W-1:0] buf_i,
  output logic [DAT_W-1:0] dat_o
);
  // byte/half loads extend from their top bit unless unsigned; words pass through
  always_comb
    dat_o = op_i == OP_LB  ? {{24{buf_i[7]}}, buf_i[7:0]} :
            op_i == OP_LBU ? {24'd0, buf_i[7:0]} :
            op_i == OP_LH  ? {{16{buf_i[15]}}, buf_i[15:0]} :
            op_i == OP_LHU ? {16'd0, buf_i[15:0]} : buf_i;
endmodule

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: byte-serial load/store engine between the load-store buffer and the RAM/IO bus
module data_mem_ctrl
  import data_mem_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             lsb_en_i,
  input  logic             lsb_rwen_i,
  input  logic [OP_W-1:0]  lsb_op_i,
  input  logic [2:0]       lsb_len_i,
  input  logic [31:0]      lsb_adr_i,
  input  logic [DAT_W-1:0] lsb_dat_i,
  input  logic             flush_i,
  input  logic             io_buffer_full,
  output logic             lsb_done_o,
  output logic [DAT_W-1:0] lsb_dat_o,
  output logic             busy_o,
  output logic [31:0]      mem_a,
  output logic [7:0]       mem_dout,
  output logic             mem_wr,
  input  logic [7:0]       mem_din
);
  state_e state_q, state_d;
  op_e op_q, op_d;
  logic [2:0] k_q, k_d, len_q, len_d, kn;
  logic [1:0] bi;
  logic [31:0] adr_q, adr_d, mem_a_q, mem_a_d;
  logic [DAT_W-1:0] dat_q, dat_d, buf_q, buf_d, rdat_q, rdat_d, ext;
  logic [7:0] dout_q, dout_d;
  logic wr_q, wr_d, done_q, done_d, acc, stall, rd_last, wr_last;
  assign acc = state_q == S_IDLE && lsb_en_i && (lsb_rwen_i || !flush_i);
  assign stall = state_q == S_WR && adr_q[17:16] == IO_WIN && io_buffer_full;
  assign kn = k_q + 3'd1;
  assign bi = k_q[1:0] - 2'd1;
  assign rd_last = k_q == len_q;
  assign wr_last = k_q == len_q - 3'd1;
  data_mem_ctrl_load_extend u_load_extend (
    .op_i  (op_q),
    .buf_i (buf_d),
    .dat_o (ext)
  );
  // state and datapath registers; en=0 freezes everything
  always_ff @(posedge clk)
    if (rst) begin
      state_q <= S_IDLE;
      op_q <= OP_LB;
      k_q <= '0;
      len_q <= '0;
      adr_q <= '0;
      dat_q <= '0;
      buf_q <= '0;
      rdat_q <= '0;
      mem_a_q <= '0;
      dout_q <= '0;
      wr_q <= 1'b0;
      done_q <= 1'b0;
    end else if (en) begin
      state_q <= state_d;
      op_q <= op_d;
      k_q <= k_d;
      len_q <= len_d;
      adr_q <= adr_d;
      dat_q <= dat_d;
      buf_q <= buf_d;
      rdat_q <= rdat_d;
      mem_a_q <= mem_a_d;
      dout_q <= dout_d;
      wr_q <= wr_d;
      done_q <= done_d;
    end
  // next state: flush aborts reads only; stores always run to completion
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: state_d = acc ? (lsb_rwen_i ? S_WR : S_RD) : S_IDLE;
      S_RD: state_d = flush_i || rd_last ? S_IDLE : S_RD;
      S_WR: state_d = !stall && wr_last ? S_IDLE : S_WR;
      default: state_d = S_IDLE;
    endcase
  end
  // load buffer: byte k arrives one cycle after its address, i.e. while the counter reads k+1
  always_comb begin
    buf_d = buf_q;
    if (acc)
      buf_d = '0;
    else if (state_q == S_RD && k_q != 3'd0)
      buf_d[{bi, 3'b000} +: 8] = mem_din;
  end
  // datapath: address/byte sequencing, registered bus pins and completion pulse
  always_comb begin
    op_d = op_q;
    k_d = k_q;
    len_d = len_q;
    adr_d = adr_q;
    dat_d = dat_q;
    rdat_d = rdat_q;
    mem_a_d = '0;
    dout_d = dout_q;
    wr_d = 1'b0;
    done_d = 1'b0;
    if (acc) begin
      op_d = op_e'(lsb_op_i);
      k_d = '0;
      len_d = lsb_len_i;
      adr_d = lsb_adr_i;
      mem_a_d = lsb_adr_i;
      dout_d = lsb_dat_i[7:0];
      dat_d = lsb_dat_i >> 8;
      wr_d = lsb_rwen_i;
    end else if (state_q == S_RD && !flush_i) begin
      k_d = rd_last ? 3'd0 : kn;
      mem_a_d = kn < len_q ? adr_q + {29'd0, kn} : '0;
      done_d = rd_last;
      rdat_d = rd_last ? ext : rdat_q;
    end else if (state_q == S_WR && stall) begin
      mem_a_d = mem_a_q;
      wr_d = 1'b1;
    end else if (state_q == S_WR && wr_last) begin
      k_d = '0;
      done_d = 1'b1;
    end else if (state_q == S_WR) begin
      k_d = kn;
      mem_a_d = adr_q + {29'd0, kn};
      dout_d = dat_q[7:0];
      dat_d = dat_q >> 8;
      wr_d = 1'b1;
    end
  end
  // outputs: a pending IO byte or a frozen pipeline never strobes mem_wr
  always_comb begin
    mem_a = mem_a_q;
    mem_dout = dout_q;
    mem_wr = wr_q & en & ~stall;
    lsb_done_o = done_q;
    lsb_dat_o = rdat_q;
    busy_o = state_q != S_IDLE;
  end
endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb_data_mem_ctrl: scoreboard bench for data_mem_ctrl against a one-cycle-latency RAM model
module tb_data_mem_ctrl;
  import data_mem_ctrl_pkg::*;
  typedef struct { int cyc; logic [31:0] a; logic [7:0] d; } wr_t;
  typedef struct { int cyc; logic [31:0] dat; } dn_t;
  logic clk = 1'b0, rst = 1'b1, en = 1'b1, lsb_en_i = 1'b0, lsb_rwen_i = 1'b0;
  logic flush_i = 1'b0, io_buffer_full = 1'b0;
  logic [OP_W-1:0] lsb_op_i = '0;
  logic [2:0] lsb_len_i = '0;
  logic [31:0] lsb_adr_i = '0, lsb_dat_i = '0, last_ld = '0;
  logic [7:0] mem_din = '0;
  logic lsb_done_o, busy_o, mem_wr;
  logic [31:0] lsb_dat_o, mem_a;
  logic [7:0] mem_dout;
  int cyc = 0, checks = 0, errors = 0;
  wr_t wq[$];
  dn_t dq[$];
  wr_t wm;
  dn_t dm;
  data_mem_ctrl dut (
    .clk(clk), .rst(rst), .en(en), .lsb_en_i(lsb_en_i), .lsb_rwen_i(lsb_rwen_i),
    .lsb_op_i(lsb_op_i), .lsb_len_i(lsb_len_i), .lsb_adr_i(lsb_adr_i), .lsb_dat_i(lsb_dat_i),
    .flush_i(flush_i), .io_buffer_full(io_buffer_full), .lsb_done_o(lsb_done_o),
    .lsb_dat_o(lsb_dat_o), .busy_o(busy_o), .mem_a(mem_a), .mem_dout(mem_dout),
    .mem_wr(mem_wr), .mem_din(mem_din)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic logic [7:0] ram_byte(input logic [31:0] a);
    case (a)
      32'h100: return 8'h78;
      32'h101: return 8'h56;
      32'h102: return 8'h34;
      32'h103: return 8'h12;
      32'h40: return 8'h80;
      32'h8001: return 8'h01;
      32'h8002: return 8'h80;
      default: return a[7:0] ^ 8'hA5;
    endcase
  endfunction
  always @(posedge clk) mem_din <= ram_byte(mem_a);
  function automatic logic [2:0] len_of(input op_e op);
    return (op == OP_LW || op == OP_SW) ? 3'd4 : (op == OP_LH || op == OP_LHU || op == OP_SH) ? 3'd2 : 3'd1;
  endfunction
  function automatic logic [31:0] exp_load(input op_e op, input logic [31:0] a);
    logic [31:0] w;
    w = {ram_byte(a + 32'd3), ram_byte(a + 32'd2), ram_byte(a + 32'd1), ram_byte(a)};
    case (op)
      OP_LB: return {{24{w[7]}}, w[7:0]};
      OP_LBU: return {24'd0, w[7:0]};
      OP_LH: return {{16{w[15]}}, w[15:0]};
      OP_LHU: return {16'd0, w[15:0]};
      default: return w;
    endcase
  endfunction
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask
  task automatic issue(input op_e op, input logic [31:0] a, input logic [31:0] d, input int stall, input bit want_done, input int nwr);
    logic [2:0] n;
    bit rw;
    int t0;
    wr_t w;
    dn_t e;
    n = len_of(op);
    rw = op == OP_SB || op == OP_SH || op == OP_SW;
    lsb_en_i = 1'b1;
    lsb_rwen_i = rw;
    lsb_op_i = op;
    lsb_len_i = n;
    lsb_adr_i = a;
    lsb_dat_i = d;
    t0 = cyc;
    if (rw)
      for (int k = 0; k < nwr; k++) begin
        w.cyc = t0 + 1 + k + stall;
        w.a = a + k;
        w.d = d[8*k +: 8];
        wq.push_back(w);
      end
    if (want_done) begin
      if (!rw) last_ld = exp_load(op, a);
      e.cyc = t0 + int'(n) + (rw ? 1 + stall : 2);
      e.dat = last_ld;
      dq.push_back(e);
    end
    @(negedge clk);
    lsb_en_i = 1'b0;
  endtask
  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy_o && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk(tag, {31'd0, busy_o}, 32'd0);
    repeat (2) @(negedge clk);
  endtask
  // pop expected bus writes and completions as the DUT produces them
  always @(negedge clk) begin
    if (mem_wr === 1'b1) begin
      if (wq.size() == 0) chk("wr_unexpected", 32'd1, 32'd0);
      else begin
        wm = wq.pop_front();
        chk("wr_cycle", cyc, wm.cyc);
        chk("wr_adr", mem_a, wm.a);
        chk("wr_dat", {24'd0, mem_dout}, {24'd0, wm.d});
      end
    end
    if (lsb_done_o === 1'b1) begin
      if (dq.size() == 0) chk("done_unexpected", 32'd1, 32'd0);
      else begin
        dm = dq.pop_front();
        chk("done_cycle", cyc, dm.cyc);
        chk("done_dat", lsb_dat_o, dm.dat);
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end
  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_busy", {31'd0, busy_o}, 32'd0);
    chk("rst_mem_a", mem_a, 32'd0);
    chk("rst_mem_wr", {31'd0, mem_wr}, 32'd0);
    chk("rst_done", {31'd0, lsb_done_o}, 32'd0);
    chk("rst_dat", lsb_dat_o, 32'd0);
    @(negedge clk);
    issue(OP_LW, 32'h100, 32'd0, 0, 1'b1, 0);
    for (int k = 0; k < 4; k++) begin
      chk("lw_mem_a", mem_a, 32'h100 + k);
      @(negedge clk);
    end
    wait_idle("lw_idle");
    issue(OP_LB, 32'h40, 32'd0, 0, 1'b1, 0);
    wait_idle("lb_idle");
    issue(OP_LBU, 32'h40, 32'd0, 0, 1'b1, 0);
    wait_idle("lbu_idle");
    issue(OP_LH, 32'h8001, 32'd0, 0, 1'b1, 0);
    wait_idle("lh_idle");
    issue(OP_LHU, 32'h8001, 32'd0, 0, 1'b1, 0);
    wait_idle("lhu_idle");
    issue(OP_LW, 32'hFFFF_FFFE, 32'd0, 0, 1'b1, 0);
    wait_idle("lw_wrap_idle");
    issue(OP_SW, 32'h200, 32'hDEAD_BEEF, 0, 1'b1, 4);
    wait_idle("sw_idle");
    issue(OP_SH, 32'hFFFF_FFFF, 32'h0000_A55A, 0, 1'b1, 2);
    wait_idle("sh_wrap_idle");
    io_buffer_full = 1'b1;
    issue(OP_SB, 32'h30000, 32'h41, 3, 1'b1, 1);
    repeat (3) @(negedge clk);
    io_buffer_full = 1'b0;
    wait_idle("sb_io_idle");
    io_buffer_full = 1'b1;
    issue(OP_SB, 32'h200, 32'h41, 0, 1'b1, 1);
    repeat (3) @(negedge clk);
    io_buffer_full = 1'b0;
    wait_idle("sb_ram_idle");
    issue(OP_LW, 32'h100, 32'd0, 0, 1'b0, 0);
    repeat (2) @(negedge clk);
    flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
    chk("rd_flush_idle", {31'd0, busy_o}, 32'd0);
    chk("rd_flush_mem_a", mem_a, 32'd0);
    wait_idle("rd_flush_wait");
    issue(OP_SW, 32'h400, 32'h0102_0304, 0, 1'b1, 4);
    flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
    wait_idle("wr_flush_idle");
    flush_i = 1'b1;
    issue(OP_LB, 32'h40, 32'd0, 0, 1'b0, 0);
    flush_i = 1'b0;
    chk("idle_flush_rd_drop", {31'd0, busy_o}, 32'd0);
    wait_idle("idle_flush_rd_wait");
    flush_i = 1'b1;
    issue(OP_SB, 32'h500, 32'h7E, 0, 1'b1, 1);
    flush_i = 1'b0;
    wait_idle("idle_flush_wr_idle");
    issue(OP_SW, 32'h300, 32'h1122_3344, 0, 1'b0, 2);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    last_ld = '0;
    chk("mid_rst_busy", {31'd0, busy_o}, 32'd0);
    chk("mid_rst_mem_wr", {31'd0, mem_wr}, 32'd0);
    chk("mid_rst_mem_a", mem_a, 32'd0);
    chk("mid_rst_dout", {24'd0, mem_dout}, 32'd0);
    chk("mid_rst_done", {31'd0, lsb_done_o}, 32'd0);
    chk("mid_rst_dat", lsb_dat_o, 32'd0);
    repeat (2) @(negedge clk);
    issue(OP_LW, 32'h100, 32'd0, 0, 1'b1, 0);
    wait_idle("post_rst_lw_idle");
    repeat (4) @(negedge clk);
    chk("wr_queue_left", wq.size(), 32'd0);
    chk("done_queue_left", dq.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
